// File: rtl/dgt_raddr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dgt_raddr_scheduler_if
// Purpose  : Groups the control, request and beat signals of the read-address
//            scheduler into one bundle.
// Ports    : slave modport  - scheduler side (inputs in, beat/status out)
//            master modport - requester/consumer side
// Signals  : en_i, flush_i, start_i, start_ready_o, mode_i, req_i,
//            addr_upper_bound_i, valid_o, ready_i, lane_valid_o, idx_o,
//            last_o, done_o, issued_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
interface dgt_raddr_scheduler_if #(
    parameter int NUM_REQ    = 256,
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 6
);
    logic                          en_i;
    logic                          flush_i;
    logic                          start_i;
    logic                          start_ready_o;
    logic                          mode_i;
    logic [NUM_REQ-1:0]            req_i;
    logic [ADDR_WIDTH-1:0]         addr_upper_bound_i;
    logic                          valid_o;
    logic                          ready_i;
    logic [NUM_PORTS-1:0]          lane_valid_o;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] idx_o;
    logic                          last_o;
    logic                          done_o;
    logic [ADDR_WIDTH:0]           issued_cnt_o;

    modport slave (
        input  en_i, flush_i, start_i, mode_i, req_i, addr_upper_bound_i, ready_i,
        output start_ready_o, valid_o, lane_valid_o, idx_o, last_o, done_o, issued_cnt_o
    );

    modport master (
        output en_i, flush_i, start_i, mode_i, req_i, addr_upper_bound_i, ready_i,
        input  start_ready_o, valid_o, lane_valid_o, idx_o, last_o, done_o, issued_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/dgt_raddr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dgt_raddr_scheduler
// Purpose  : Captures a request vector as a per-block pending mask and issues
//            the pending block indices in ascending order, up to NUM_PORTS
//            indices per valid/ready beat.
// Ports    : clk_i - clock
//            rst_i - asynchronous active-high reset
//            bus   - dgt_raddr_scheduler_if.slave (control, request, beat,
//                    completion pulse and issued-index counter)
// Revision : 1.0 - initial release
// ============================================================================
module dgt_raddr_scheduler #(
    parameter int NUM_REQ      = 256,
    parameter int PARALLELISM  = 4,
    parameter int NUM_PORTS    = 2,
    parameter int LSB_PRIORITY = 0
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    dgt_raddr_scheduler_if.slave    bus
);
    localparam int NUM_BLOCKS = NUM_REQ / PARALLELISM;
    localparam int ADDR_WIDTH = $clog2(NUM_BLOCKS);
    localparam int CNT_W      = ADDR_WIDTH + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_BLOCKS-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_pend_q, done_pend_d;

    logic [NUM_BLOCKS-1:0]   load_mask;
    logic [NUM_BLOCKS-1:0]   take_mask;
    logic [NUM_PORTS-1:0]    lane_valid_c;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] idx_c;
    int                      fill;
    int                      pend_cnt;
    logic                    valid;
    logic                    last;
    logic                    start_acc;
    logic                    handshake;

    // Mask that an accepted start would load. Index k looks at block k when
    // LSB_PRIORITY is set, otherwise at the mirrored block.
    always_comb begin
        load_mask = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            int p;
            p = (LSB_PRIORITY != 0) ? k : (NUM_BLOCKS - 1 - k);
            load_mask[k] = (bus.mode_i | (|bus.req_i[p*PARALLELISM +: PARALLELISM]))
                         & (k <= int'(bus.addr_upper_bound_i));
        end
    end

    // Lane packing: walk the pending mask from index 0 upward and drop each
    // pending index into the next free lane, so lanes fill as a thermometer.
    always_comb begin
        lane_valid_c = '0;
        idx_c        = '0;
        take_mask    = '0;
        fill         = 0;
        pend_cnt     = 0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (mask_q[k]) begin
                pend_cnt = pend_cnt + 1;
                if (fill < NUM_PORTS) begin
                    idx_c[fill*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(k);
                    lane_valid_c[fill] = 1'b1;
                    take_mask[k]       = 1'b1;
                    fill               = fill + 1;
                end
            end
        end
    end

    assign valid     = bus.en_i & (state_q == S_ISSUE);
    assign last      = valid & (pend_cnt <= NUM_PORTS);
    assign handshake = valid & bus.ready_i;
    assign start_acc = bus.start_i & bus.en_i & (state_q == S_IDLE);

    assign bus.start_ready_o = bus.en_i & (state_q == S_IDLE);
    assign bus.valid_o       = valid;
    assign bus.lane_valid_o  = valid ? lane_valid_c : '0;
    assign bus.idx_o         = valid ? idx_c : '0;
    assign bus.last_o        = last;
    // A completion pulse raised while disabled waits until en_i returns.
    assign bus.done_o        = done_pend_q & bus.en_i;
    assign bus.issued_cnt_o  = cnt_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        done_pend_d = done_pend_q;
        if (bus.flush_i) begin
            state_d     = S_IDLE;
            mask_d      = '0;
            done_pend_d = 1'b0;
        end else if (bus.en_i) begin
            // The pulse is visible this cycle, so it retires now.
            done_pend_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        mask_d = load_mask;
                        cnt_d  = '0;
                        if (|load_mask) begin
                            state_d = S_ISSUE;
                        end else begin
                            done_pend_d = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (handshake) begin
                        mask_d = mask_q & ~take_mask;
                        cnt_d  = cnt_q + CNT_W'(fill);
                        if (last) begin
                            state_d     = S_IDLE;
                            done_pend_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            cnt_q       <= '0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            done_pend_q <= done_pend_d;
        end
    end
endmodule
`default_nettype wire
